// File: rtl/modaddsub_pipe.sv
// Multi-lane modular add/sub for q = {qH, 0..0, 1}: raw sum/difference, one conditional correction.
// Latency FF_IN+FF_ADD+FF_OUT; out_valid && !out_ready freezes every stage and drops in_ready.
module modaddsub_pipe #(
    parameter int LANES  = 4,
    parameter int LOGQ   = 64,
    parameter int LOGQH  = 47,
    parameter int TAGW   = 8,
    parameter int FF_IN  = 1,
    parameter int FF_ADD = 1,
    parameter int FF_OUT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sub,
    input  logic [TAGW-1:0]       in_tag,
    input  logic [LANES*LOGQ-1:0] in_a,
    input  logic [LANES*LOGQ-1:0] in_b,
    input  logic [LOGQH-1:0]      qH,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TAGW-1:0]       out_tag,
    output logic [LANES*LOGQ-1:0] out_c
);
    localparam int DW  = LANES * LOGQ;
    localparam int LZ  = LOGQ - LOGQH - 1;
    localparam int LAT = FF_IN + FF_ADD + FF_OUT;

    logic             w_adv;
    logic             w_s0_vld;
    logic             w_s0_sub;
    logic [TAGW-1:0]  w_s0_tag;
    logic [DW-1:0]    w_s0_a;
    logic [DW-1:0]    w_s0_b;
    logic [LOGQH-1:0] w_s0_qh;
    logic [LOGQ-1:0]  w_q;
    logic [DW-1:0]    w_cp;
    logic [DW-1:0]    w_cc;
    logic [LANES-1:0] w_sel;
    logic             w_s1_vld;
    logic [TAGW-1:0]  w_s1_tag;
    logic [DW-1:0]    w_s1_cp;
    logic [DW-1:0]    w_s1_cc;
    logic [LANES-1:0] w_s1_sel;
    logic [DW-1:0]    w_res;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = (LAT == 0) ? out_ready : w_adv;

    if (FF_IN != 0) begin : g_in_ff
        logic             r_vld;
        logic             r_sub;
        logic [TAGW-1:0]  r_tag;
        logic [DW-1:0]    r_a;
        logic [DW-1:0]    r_b;
        logic [LOGQH-1:0] r_qh;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_sub <= 1'b0;
                r_tag <= '0;
                r_a   <= '0;
                r_b   <= '0;
                r_qh  <= '0;
            end else if (w_adv) begin
                r_vld <= in_valid;
                if (in_valid) begin
                    r_sub <= in_sub;
                    r_tag <= in_tag;
                    r_a   <= in_a;
                    r_b   <= in_b;
                    r_qh  <= qH;
                end
            end
        end
        assign w_s0_vld = r_vld;
        assign w_s0_sub = r_sub;
        assign w_s0_tag = r_tag;
        assign w_s0_a   = r_a;
        assign w_s0_b   = r_b;
        assign w_s0_qh  = r_qh;
    end else begin : g_in_comb
        assign w_s0_vld = in_valid;
        assign w_s0_sub = in_sub;
        assign w_s0_tag = in_tag;
        assign w_s0_a   = in_a;
        assign w_s0_b   = in_b;
        assign w_s0_qh  = qH;
    end

    assign w_q = {w_s0_qh, {LZ{1'b0}}, 1'b1};

    // Primary candidate is the plain sum/difference, alternate is the once-corrected
    // value; the select bit marks when the alternate is the in-range result.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LOGQ-1:0] w_a;
        logic [LOGQ-1:0] w_b;
        logic [LOGQ:0]   w_sum;
        logic [LOGQ:0]   w_dif;
        logic [LOGQ-1:0] w_red;
        logic [LOGQ-1:0] w_fix;
        assign w_a   = w_s0_a[i*LOGQ +: LOGQ];
        assign w_b   = w_s0_b[i*LOGQ +: LOGQ];
        assign w_sum = {1'b0, w_a} + {1'b0, w_b};
        assign w_dif = {1'b0, w_a} - {1'b0, w_b};
        assign w_red = w_sum[LOGQ-1:0] - w_q;
        assign w_fix = w_dif[LOGQ-1:0] + w_q;
        assign w_cp[i*LOGQ +: LOGQ] = w_s0_sub ? w_dif[LOGQ-1:0] : w_sum[LOGQ-1:0];
        assign w_cc[i*LOGQ +: LOGQ] = w_s0_sub ? w_fix : w_red;
        assign w_sel[i] = w_s0_sub ? w_dif[LOGQ] : (w_sum >= {1'b0, w_q});
        assign w_res[i*LOGQ +: LOGQ] = w_s1_sel[i] ? w_s1_cc[i*LOGQ +: LOGQ]
                                                   : w_s1_cp[i*LOGQ +: LOGQ];
    end

    if (FF_ADD != 0) begin : g_add_ff
        logic             r_vld;
        logic [TAGW-1:0]  r_tag;
        logic [DW-1:0]    r_cp;
        logic [DW-1:0]    r_cc;
        logic [LANES-1:0] r_sel;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_tag <= '0;
                r_cp  <= '0;
                r_cc  <= '0;
                r_sel <= '0;
            end else if (w_adv) begin
                r_vld <= w_s0_vld;
                if (w_s0_vld) begin
                    r_tag <= w_s0_tag;
                    r_cp  <= w_cp;
                    r_cc  <= w_cc;
                    r_sel <= w_sel;
                end
            end
        end
        assign w_s1_vld = r_vld;
        assign w_s1_tag = r_tag;
        assign w_s1_cp  = r_cp;
        assign w_s1_cc  = r_cc;
        assign w_s1_sel = r_sel;
    end else begin : g_add_comb
        assign w_s1_vld = w_s0_vld;
        assign w_s1_tag = w_s0_tag;
        assign w_s1_cp  = w_cp;
        assign w_s1_cc  = w_cc;
        assign w_s1_sel = w_sel;
    end

    if (FF_OUT != 0) begin : g_out_ff
        logic            r_vld;
        logic [TAGW-1:0] r_tag;
        logic [DW-1:0]   r_c;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_tag <= '0;
                r_c   <= '0;
            end else if (w_adv) begin
                r_vld <= w_s1_vld;
                if (w_s1_vld) begin
                    r_tag <= w_s1_tag;
                    r_c   <= w_res;
                end
            end
        end
        assign out_valid = r_vld;
        assign out_tag   = r_tag;
        assign out_c     = r_c;
    end else begin : g_out_comb
        assign out_valid = w_s1_vld;
        assign out_tag   = w_s1_tag;
        assign out_c     = w_res;
    end
endmodule

// File: tb/tb_modaddsub_pipe.sv
// Bench for modaddsub_pipe: q = 241 config at latencies 3, 0 and 1 sharing one input stream.
module tb_modaddsub_pipe;
    localparam int LANES = 2;
    localparam int LOGQ  = 8;
    localparam int LOGQH = 5;
    localparam int TAGW  = 4;
    localparam int DW    = LANES * LOGQ;

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [DW-1:0]   c;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_sub;
    logic [TAGW-1:0] in_tag;
    logic [DW-1:0]   in_a;
    logic [DW-1:0]   in_b;
    logic [LOGQH-1:0] qh;

    logic in_ready_m, out_valid_m, out_ready_m;
    logic in_ready_z, out_valid_z, out_ready_z;
    logic in_ready_o, out_valid_o, out_ready_o;
    logic [TAGW-1:0] out_tag_m, out_tag_z, out_tag_o;
    logic [DW-1:0]   out_c_m, out_c_z, out_c_o;

    exp_t q_m[$];
    exp_t q_z[$];
    exp_t q_o[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    modaddsub_pipe #(.LANES(LANES), .LOGQ(LOGQ), .LOGQH(LOGQH), .TAGW(TAGW),
                     .FF_IN(1), .FF_ADD(1), .FF_OUT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_sub(in_sub), .in_tag(in_tag), .in_a(in_a), .in_b(in_b), .qH(qh),
        .out_valid(out_valid_m), .out_ready(out_ready_m), .out_tag(out_tag_m), .out_c(out_c_m));

    modaddsub_pipe #(.LANES(LANES), .LOGQ(LOGQ), .LOGQH(LOGQH), .TAGW(TAGW),
                     .FF_IN(0), .FF_ADD(0), .FF_OUT(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z),
        .in_sub(in_sub), .in_tag(in_tag), .in_a(in_a), .in_b(in_b), .qH(qh),
        .out_valid(out_valid_z), .out_ready(out_ready_z), .out_tag(out_tag_z), .out_c(out_c_z));

    modaddsub_pipe #(.LANES(LANES), .LOGQ(LOGQ), .LOGQH(LOGQH), .TAGW(TAGW),
                     .FF_IN(0), .FF_ADD(1), .FF_OUT(0)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o),
        .in_sub(in_sub), .in_tag(in_tag), .in_a(in_a), .in_b(in_b), .qH(qh),
        .out_valid(out_valid_o), .out_ready(out_ready_o), .out_tag(out_tag_o), .out_c(out_c_o));

    // Reference: integer modular arithmetic on the beat currently presented.
    function automatic exp_t model_beat();
        exp_t e;
        int   q, a, b, r;
        q = int'(qh) * (2 ** (LOGQ - LOGQH)) + 1;
        e.tag = in_tag;
        e.c   = '0;
        for (int i = 0; i < LANES; i++) begin
            a = int'(in_a[i*LOGQ +: LOGQ]);
            b = int'(in_b[i*LOGQ +: LOGQ]);
            if (!in_sub) r = (a + b >= q) ? a + b - q : a + b;
            else         r = (a >= b) ? a - b : a - b + q;
            e.c[i*LOGQ +: LOGQ] = r[LOGQ-1:0];
        end
        return e;
    endfunction

    function automatic logic [LOGQ-1:0] rnd_op();
        int q;
        q = int'(qh) * (2 ** (LOGQ - LOGQH)) + 1;
        return LOGQ'($urandom_range(0, q - 1));
    endfunction

    task automatic set_beat(input logic sub, input logic [TAGW-1:0] tag,
                            input logic [LOGQ-1:0] a0, input logic [LOGQ-1:0] b0,
                            input logic [LOGQ-1:0] a1, input logic [LOGQ-1:0] b1);
        in_valid = 1'b1;
        in_sub   = sub;
        in_tag   = tag;
        in_a     = {a1, a0};
        in_b     = {b1, b0};
    endtask

    // Scoreboards: push on each instance's accept, pop and compare on each drain.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready_m) q_m.push_back(model_beat());
            if (in_valid && in_ready_z) q_z.push_back(model_beat());
            if (in_valid && in_ready_o) q_o.push_back(model_beat());
            if (out_valid_m && out_ready_m) begin
                n_chk++;
                if (q_m.size() == 0) $display("FAIL sb_lat3: unexpected beat tag=%0h c=%0h, expected none", out_tag_m, out_c_m);
                else begin
                    mon_e = q_m.pop_front();
                    if ({out_tag_m, out_c_m} !== mon_e) $display("FAIL sb_lat3: got tag=%0h c=%0h, expected tag=%0h c=%0h", out_tag_m, out_c_m, mon_e.tag, mon_e.c);
                    else n_pass++;
                end
            end
            if (out_valid_z && out_ready_z) begin
                n_chk++;
                if (q_z.size() == 0) $display("FAIL sb_lat0: unexpected beat tag=%0h c=%0h, expected none", out_tag_z, out_c_z);
                else begin
                    mon_e = q_z.pop_front();
                    if ({out_tag_z, out_c_z} !== mon_e) $display("FAIL sb_lat0: got tag=%0h c=%0h, expected tag=%0h c=%0h", out_tag_z, out_c_z, mon_e.tag, mon_e.c);
                    else n_pass++;
                end
            end
            if (out_valid_o && out_ready_o) begin
                n_chk++;
                if (q_o.size() == 0) $display("FAIL sb_lat1: unexpected beat tag=%0h c=%0h, expected none", out_tag_o, out_c_o);
                else begin
                    mon_e = q_o.pop_front();
                    if ({out_tag_o, out_c_o} !== mon_e) $display("FAIL sb_lat1: got tag=%0h c=%0h, expected tag=%0h c=%0h", out_tag_o, out_c_o, mon_e.tag, mon_e.c);
                    else n_pass++;
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_tag = '0; in_a = '0; in_b = '0;
        qh = 5'b11110; out_ready_m = 1'b1; out_ready_z = 1'b1; out_ready_o = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (out_valid_m !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid_m); else n_pass++;
        n_chk++; if (in_ready_m !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready_m); else n_pass++;
        n_chk++; if (out_c_m !== '0) $display("FAIL reset_out_c: got %0h want 0", out_c_m); else n_pass++;
        n_chk++; if (out_tag_m !== '0) $display("FAIL reset_out_tag: got %0h want 0", out_tag_m); else n_pass++;
        n_chk++; if (out_valid_o !== 1'b0) $display("FAIL reset_lat1_valid: got %0b want 0", out_valid_o); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_add_wrap();
        int lat_m = -1, lat_z = -1, lat_o = -1;
        exp_t g_m, g_z, g_o;
        g_m = '0; g_z = '0; g_o = '0;
        set_beat(1'b0, 4'd3, 8'd200, 8'd40, 8'd240, 8'd1);
        for (int c = 0; c < 10 && lat_m < 0; c++) begin
            @(negedge clk);
            if (lat_m < 0 && out_valid_m === 1'b1) begin lat_m = c; g_m = {out_tag_m, out_c_m}; end
            if (lat_z < 0 && out_valid_z === 1'b1) begin lat_z = c; g_z = {out_tag_z, out_c_z}; end
            if (lat_o < 0 && out_valid_o === 1'b1) begin lat_o = c; g_o = {out_tag_o, out_c_o}; end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        n_chk++; if (lat_m != 3) $display("FAIL addwrap_lat3: got latency %0d want 3", lat_m); else n_pass++;
        n_chk++; if (lat_z != 0) $display("FAIL addwrap_lat0: got latency %0d want 0", lat_z); else n_pass++;
        n_chk++; if (lat_o != 1) $display("FAIL addwrap_lat1: got latency %0d want 1", lat_o); else n_pass++;
        n_chk++; if (g_m !== {4'd3, 8'd0, 8'd240}) $display("FAIL addwrap_data3: got %0h want 300f0", g_m); else n_pass++;
        n_chk++; if (g_z !== {4'd3, 8'd0, 8'd240}) $display("FAIL addwrap_data0: got %0h want 300f0", g_z); else n_pass++;
        n_chk++; if (g_o !== {4'd3, 8'd0, 8'd240}) $display("FAIL addwrap_data1: got %0h want 300f0", g_o); else n_pass++;
    endtask

    task automatic test_reduce_sub();
        logic [DW-1:0] want [3];
        int k = 0;
        want[0] = {8'd240, 8'd59};
        want[1] = {8'd10, 8'd231};
        want[2] = {8'd240, 8'd1};
        for (int c = 0; c < 12; c++) begin
            case (c)
                0: set_beat(1'b0, 4'd4, 8'd200, 8'd100, 8'd120, 8'd120);
                1: set_beat(1'b1, 4'd5, 8'd10, 8'd20, 8'd20, 8'd10);
                2: set_beat(1'b1, 4'd6, 8'd0, 8'd240, 8'd240, 8'd0);
                default: in_valid = 1'b0;
            endcase
            @(negedge clk);
            if (out_valid_m === 1'b1) begin
                n_chk++;
                if (k > 2 || out_c_m !== want[k] || out_tag_m !== 4'(k + 4))
                    $display("FAIL redsub_beat%0d: got tag=%0h c=%0h", k, out_tag_m, out_c_m);
                else n_pass++;
                k++;
            end
            @(posedge clk); #1;
        end
        n_chk++; if (k != 3) $display("FAIL redsub_count: got %0d beats want 3", k); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 13; c++) begin
            if (c < 8) set_beat(c[0], 4'(c), rnd_op(), rnd_op(), rnd_op(), rnd_op());
            else in_valid = 1'b0;
            @(negedge clk);
            n_chk++;
            if (out_valid_m !== (c >= 3 && c <= 10)) $display("FAIL b2b_valid_c%0d: got %0b want %0b", c, out_valid_m, (c >= 3 && c <= 10));
            else n_pass++;
            if (c >= 3 && c <= 10) begin
                n_chk++;
                if (out_tag_m !== 4'(c - 3)) $display("FAIL b2b_tag_c%0d: got %0h want %0h", c, out_tag_m, c - 3);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int   sent = 0, rcv = 0;
        bit   held = 0, acc;
        exp_t saved;
        logic sv_vld;
        saved = '0; sv_vld = 1'b0;
        set_beat($urandom_range(0, 1) == 1, 4'd0, rnd_op(), rnd_op(), rnd_op(), rnd_op());
        for (int c = 0; c < 60 && rcv < 10; c++) begin
            out_ready_m = !(c >= 5 && c < 10);
            @(negedge clk);
            if (out_valid_m && !out_ready_m) begin
                if (!held) begin held = 1; saved = {out_tag_m, out_c_m}; sv_vld = out_valid_m; end
                else begin
                    n_chk++;
                    if ({out_tag_m, out_c_m} !== saved || out_valid_m !== sv_vld) $display("FAIL bp_hold_c%0d: got tag=%0h c=%0h want tag=%0h c=%0h", c, out_tag_m, out_c_m, saved.tag, saved.c);
                    else n_pass++;
                end
                n_chk++;
                if (in_ready_m !== 1'b0) $display("FAIL bp_in_ready_c%0d: got %0b want 0", c, in_ready_m);
                else n_pass++;
            end
            if (out_valid_m && out_ready_m) begin
                n_chk++;
                if (out_tag_m !== 4'(rcv)) $display("FAIL bp_order: got tag %0h want %0h", out_tag_m, rcv);
                else n_pass++;
                rcv++;
            end
            acc = in_valid && in_ready_m;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < 10) set_beat($urandom_range(0, 1) == 1, 4'(sent), rnd_op(), rnd_op(), rnd_op(), rnd_op());
                else in_valid = 1'b0;
            end
        end
        out_ready_m = 1'b1;
        n_chk++; if (rcv != 10) $display("FAIL bp_count: got %0d beats want 10", rcv); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [TAGW-1:0] tg [2];
        int k = 0;
        tg[0] = 4'd9; tg[1] = 4'd10;
        for (int c = 0; c < 3; c++) begin
            set_beat(c[0], 4'(c + 1), rnd_op(), rnd_op(), rnd_op(), rnd_op());
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_chk++; if (out_valid_m !== 1'b1) $display("FAIL rstmid_inflight: got %0b want 1", out_valid_m); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (out_valid_m !== 1'b0) $display("FAIL rstmid_valid: got %0b want 0", out_valid_m); else n_pass++;
        n_chk++; if (out_c_m !== '0) $display("FAIL rstmid_out_c: got %0h want 0", out_c_m); else n_pass++;
        n_chk++; if (out_tag_m !== '0) $display("FAIL rstmid_out_tag: got %0h want 0", out_tag_m); else n_pass++;
        n_chk++; if (in_ready_m !== 1'b1) $display("FAIL rstmid_in_ready: got %0b want 1", in_ready_m); else n_pass++;
        q_m.delete(); q_z.delete(); q_o.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 2) set_beat(1'b0, tg[c], rnd_op(), rnd_op(), rnd_op(), rnd_op());
            else in_valid = 1'b0;
            @(negedge clk);
            if (out_valid_m === 1'b1) begin
                n_chk++;
                if (k < 2 && out_tag_m === tg[k]) n_pass++;
                else $display("FAIL rstmid_new_beat%0d: got tag %0h", k, out_tag_m);
                k++;
            end
            @(posedge clk); #1;
        end
        n_chk++; if (k != 2) $display("FAIL rstmid_count: got %0d beats want 2", k); else n_pass++;
    endtask

    task automatic test_random();
        int sent = 0;
        bit acc;
        in_valid = 1'b0;
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            out_ready_m = ($urandom_range(0, 3) != 0);
            out_ready_z = ($urandom_range(0, 3) != 0);
            out_ready_o = ($urandom_range(0, 3) != 0);
            if (!in_valid) begin
                qh = LOGQH'($urandom_range(16, 31));
                set_beat($urandom_range(0, 1) == 1, 4'(sent), rnd_op(), rnd_op(), rnd_op(), rnd_op());
                in_valid = ($urandom_range(0, 9) < 7);
            end
            @(negedge clk);
            acc = in_valid && in_ready_m;
            @(posedge clk); #1;
            if (acc) begin sent++; in_valid = 1'b0; end
        end
        in_valid = 1'b0;
        out_ready_m = 1'b1; out_ready_z = 1'b1; out_ready_o = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_chk++; if (sent != 10000) $display("FAIL rand_sent: got %0d want 10000", sent); else n_pass++;
        n_chk++; if (q_m.size() != 0) $display("FAIL rand_drain_lat3: %0d left want 0", q_m.size()); else n_pass++;
        n_chk++; if (q_z.size() != 0) $display("FAIL rand_drain_lat0: %0d left want 0", q_z.size()); else n_pass++;
        n_chk++; if (q_o.size() != 0) $display("FAIL rand_drain_lat1: %0d left want 0", q_o.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_reduce_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
